// File: rtl/uart_rx_frame_checker_if.sv
// Bus between the RX bit sampler / register file and the frame checker.
interface uart_rx_frame_checker_if #(
  parameter int unsigned MAX_DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH      = 8
);
  logic                      frame_start;
  logic                      bit_valid;
  logic                      bit_val;
  logic [3:0]                cfg_data_len;
  logic [2:0]                cfg_par_mode;
  logic                      cfg_two_stop;
  logic                      cnt_clr;
  logic                      busy;
  logic                      out_valid;
  logic [MAX_DATA_WIDTH-1:0] out_data;
  logic                      par_err;
  logic                      stop_err;
  logic [CNT_WIDTH-1:0]      par_err_cnt;
  logic [CNT_WIDTH-1:0]      stop_err_cnt;

  modport master (
    output frame_start, bit_valid, bit_val, cfg_data_len, cfg_par_mode, cfg_two_stop, cnt_clr,
    input  busy, out_valid, out_data, par_err, stop_err, par_err_cnt, stop_err_cnt
  );

  modport slave (
    input  frame_start, bit_valid, bit_val, cfg_data_len, cfg_par_mode, cfg_two_stop, cnt_clr,
    output busy, out_valid, out_data, par_err, stop_err, par_err_cnt, stop_err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: assembles data bits from sampler strobes, checks parity and stop
// bits, and keeps saturating error counters.
module uart_rx_frame_checker #(
  parameter int unsigned MAX_DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input logic                    clk,
  input logic                    rst,
  uart_rx_frame_checker_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StData, StParity, StStop1, StStop2, StDone} state_e;

  localparam logic [3:0]           MaxLen = 4'(MAX_DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  state_e                    state_q, state_d;
  logic [3:0]                len_q;
  logic [2:0]                mode_q;
  logic                      two_stop_q;
  logic [3:0]                bit_cnt_q;
  logic [MAX_DATA_WIDTH-1:0] shift_q;
  logic                      par_acc_q;
  logic                      perr_q;
  logic                      serr_q;
  logic [MAX_DATA_WIDTH-1:0] out_data_q;
  logic                      par_err_q;
  logic                      stop_err_q;
  logic [CNT_WIDTH-1:0]      par_cnt_q;
  logic [CNT_WIDTH-1:0]      stop_cnt_q;

  logic [3:0] eff_len;
  logic       par_en;
  logic       par_exp;
  logic       finish;
  logic       stop_bad;

  // Decode latched config and the frame-completion condition.
  always_comb begin
    eff_len = bus.cfg_data_len;
    if (bus.cfg_data_len == 4'd0 || 32'(bus.cfg_data_len) > MAX_DATA_WIDTH) begin
      eff_len = MaxLen;
    end
    par_en = (mode_q != 3'd0) && (mode_q <= 3'd4);
    case (mode_q)
      3'd1:    par_exp = par_acc_q;
      3'd2:    par_exp = ~par_acc_q;
      3'd3:    par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
    // frame_start pre-empts a stop bit arriving in the same cycle
    finish = !bus.frame_start && bus.bit_valid &&
             ((state_q == StStop1 && !two_stop_q) || state_q == StStop2);
    stop_bad = ~bus.bit_val | (state_q == StStop2 && serr_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; frame_start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (bus.frame_start) begin
      state_d = StData;
    end else begin
      case (state_q)
        StIdle:   state_d = StIdle;
        StData:   if (bus.bit_valid && bit_cnt_q == len_q - 4'd1) begin
                    state_d = par_en ? StParity : StStop1;
                  end
        StParity: if (bus.bit_valid) state_d = StStop1;
        StStop1:  if (bus.bit_valid) state_d = two_stop_q ? StStop2 : StDone;
        StStop2:  if (bus.bit_valid) state_d = StDone;
        StDone:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.out_valid = (state_q == StDone);
  end

  // Per-frame datapath: config latch, shift register, parity and stop accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= 4'd0;
      mode_q     <= 3'd0;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else if (bus.frame_start) begin
      len_q      <= eff_len;
      mode_q     <= bus.cfg_par_mode;
      two_stop_q <= bus.cfg_two_stop;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else if (bus.bit_valid) begin
      case (state_q)
        StData: begin
          shift_q   <= shift_q | (MAX_DATA_WIDTH'(bus.bit_val) << bit_cnt_q);
          par_acc_q <= par_acc_q ^ bus.bit_val;
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        StParity: perr_q <= (bus.bit_val != par_exp);
        StStop1:  serr_q <= ~bus.bit_val;
        StStop2:  serr_q <= serr_q | ~bus.bit_val;
        default:  ;
      endcase
    end
  end

  // Result registers load on the final stop edge so they are valid during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else if (finish) begin
      out_data_q <= shift_q;
      par_err_q  <= perr_q;
      stop_err_q <= stop_bad;
    end
  end

  // Saturating error counters; clear beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else if (state_q == StDone) begin
      if (par_err_q && par_cnt_q != CntMax)   par_cnt_q  <= par_cnt_q + 1'b1;
      if (stop_err_q && stop_cnt_q != CntMax) stop_cnt_q <= stop_cnt_q + 1'b1;
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.par_err      = par_err_q;
  assign bus.stop_err     = stop_err_q;
  assign bus.par_err_cnt  = par_cnt_q;
  assign bus.stop_err_cnt = stop_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker. Inputs change 1 time unit after the rising edge;
// outputs are checked at that same offset.
module tb_uart_rx_frame_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  int   ov_count = 0;
  int   ov_before;

  always #5 clk = ~clk;

  uart_rx_frame_checker_if #(.MAX_DATA_WIDTH(8), .CNT_WIDTH(8)) bif ();

  uart_rx_frame_checker #(.MAX_DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // Count out_valid pulses mid-cycle.
  always @(negedge clk) if (bif.out_valid === 1'b1) ov_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_bit(input logic b);
    bif.bit_valid = 1'b1;
    bif.bit_val   = b;
    step();
    bif.bit_valid = 1'b0;
    bif.bit_val   = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] len, input logic [2:0] mode, input logic two);
    bif.cfg_data_len = len;
    bif.cfg_par_mode = mode;
    bif.cfg_two_stop = two;
  endtask

  // Returns in the cycle right after the edge that took the last stop bit.
  task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                            input logic par, input logic s1, input bit two, input logic s2,
                            input bit collide);
    bif.frame_start = 1'b1;
    if (collide) begin
      bif.bit_valid = 1'b1;
      bif.bit_val   = 1'b0;
    end
    step();
    bif.frame_start = 1'b0;
    bif.bit_valid   = 1'b0;
    for (int i = 0; i < nbits; i++) pulse_bit(data[i]);
    if (has_par) pulse_bit(par);
    pulse_bit(s1);
    if (two) pulse_bit(s2);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, " busy"},         32'(bif.busy), 0);
    check_eq({pfx, " out_valid"},    32'(bif.out_valid), 0);
    check_eq({pfx, " out_data"},     32'(bif.out_data), 0);
    check_eq({pfx, " par_err"},      32'(bif.par_err), 0);
    check_eq({pfx, " stop_err"},     32'(bif.stop_err), 0);
    check_eq({pfx, " par_err_cnt"},  32'(bif.par_err_cnt), 0);
    check_eq({pfx, " stop_err_cnt"}, 32'(bif.stop_err_cnt), 0);
  endtask

  initial begin
    bif.frame_start = 1'b0;
    bif.bit_valid   = 1'b0;
    bif.bit_val     = 1'b0;
    bif.cnt_clr     = 1'b0;
    set_cfg(4'd8, 3'd1, 1'b0);
    step();
    step();
    check_zero_outputs("reset");
    rst = 1'b1;
    step();

    // 0xA5 has four ones: even parity bit 0.
    send_frame(8'hA5, 8, 1, 1'b0, 1'b1, 0, 1'b1, 0);
    check_eq("a5 out_valid", 32'(bif.out_valid), 1);
    check_eq("a5 out_data", 32'(bif.out_data), 32'hA5);
    check_eq("a5 par_err", 32'(bif.par_err), 0);
    check_eq("a5 stop_err", 32'(bif.stop_err), 0);
    step();
    check_eq("a5 out_valid drop", 32'(bif.out_valid), 0);
    check_eq("a5 busy drop", 32'(bif.busy), 0);
    check_eq("a5 out_data hold", 32'(bif.out_data), 32'hA5);

    // 0x3C has four ones: odd parity bit should be 1, so 0 is the erroneous one.
    set_cfg(4'd8, 3'd2, 1'b0);
    send_frame(8'h3C, 8, 1, 1'b0, 1'b1, 0, 1'b1, 0);
    check_eq("odd par_err", 32'(bif.par_err), 1);
    check_eq("odd cnt before", 32'(bif.par_err_cnt), 0);
    step();
    check_eq("odd cnt after", 32'(bif.par_err_cnt), 1);

    // Clear coincides with an increment in DONE: clear wins.
    send_frame(8'h3C, 8, 1, 1'b0, 1'b1, 0, 1'b1, 0);
    check_eq("clr par_err", 32'(bif.par_err), 1);
    bif.cnt_clr = 1'b1;
    step();
    bif.cnt_clr = 1'b0;
    check_eq("clr par_err_cnt", 32'(bif.par_err_cnt), 0);

    // 5 data bits, no parity, two stops with the second one bad.
    set_cfg(4'd5, 3'd0, 1'b1);
    send_frame(8'h13, 5, 0, 1'b0, 1'b1, 1, 1'b0, 0);
    check_eq("len5 out_valid", 32'(bif.out_valid), 1);
    check_eq("len5 out_data", 32'(bif.out_data), 32'h13);
    check_eq("len5 stop_err", 32'(bif.stop_err), 1);
    check_eq("len5 par_err", 32'(bif.par_err), 0);
    step();
    check_eq("len5 stop_err_cnt", 32'(bif.stop_err_cnt), 1);

    // Mark parity with length 0 (means 8): parity bit 0 is an error.
    set_cfg(4'd0, 3'd3, 1'b0);
    send_frame(8'h00, 8, 1, 1'b0, 1'b1, 0, 1'b1, 0);
    check_eq("mark out_valid", 32'(bif.out_valid), 1);
    check_eq("mark par_err", 32'(bif.par_err), 1);
    step();

    // Space parity with length 12 (clamped to 8): parity bit 0 is fine.
    set_cfg(4'd12, 3'd4, 1'b0);
    send_frame(8'hFF, 8, 1, 1'b0, 1'b1, 0, 1'b1, 0);
    check_eq("space out_valid", 32'(bif.out_valid), 1);
    check_eq("space out_data", 32'(bif.out_data), 32'hFF);
    check_eq("space par_err", 32'(bif.par_err), 0);
    step();

    // Reserved mode 5 behaves as no parity: the bit after data is the stop bit.
    set_cfg(4'd8, 3'd5, 1'b0);
    send_frame(8'h81, 8, 0, 1'b0, 1'b1, 0, 1'b1, 0);
    check_eq("mode5 out_valid", 32'(bif.out_valid), 1);
    check_eq("mode5 out_data", 32'(bif.out_data), 32'h81);
    check_eq("mode5 par_err", 32'(bif.par_err), 0);
    step();

    // Abort after 3 bits; the restart carries a colliding bit that must be dropped.
    set_cfg(4'd8, 3'd1, 1'b0);
    ov_before = ov_count;
    bif.frame_start = 1'b1;
    step();
    bif.frame_start = 1'b0;
    for (int i = 0; i < 3; i++) pulse_bit(1'b1);
    check_eq("abort busy", 32'(bif.busy), 1);
    send_frame(8'h55, 8, 1, 1'b0, 1'b1, 0, 1'b1, 1);
    check_eq("abort out_data", 32'(bif.out_data), 32'h55);
    check_eq("abort par_err", 32'(bif.par_err), 0);
    step();
    check_eq("abort ov pulses", 32'(ov_count - ov_before), 1);
    check_eq("abort par_err_cnt", 32'(bif.par_err_cnt), 1);
    check_eq("abort stop_err_cnt", 32'(bif.stop_err_cnt), 1);

    // Asynchronous reset mid-frame.
    ov_before = ov_count;
    bif.frame_start = 1'b1;
    step();
    bif.frame_start = 1'b0;
    for (int i = 0; i < 4; i++) pulse_bit(1'b1);
    rst = 1'b0;
    #2;
    check_zero_outputs("midrst");
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) pulse_bit(1'b1);
    check_eq("midrst no pulse", 32'(ov_count - ov_before), 0);
    check_eq("midrst idle", 32'(bif.busy), 0);

    // Saturation: 0x01 with even parity wants 1; send 0 every frame.
    for (int i = 0; i < 300; i++) send_frame(8'h01, 8, 1, 1'b0, 1'b1, 0, 1'b1, 0);
    step();
    check_eq("sat par_err_cnt", 32'(bif.par_err_cnt), 255);
    check_eq("sat stop_err_cnt", 32'(bif.stop_err_cnt), 0);
    send_frame(8'h01, 8, 1, 1'b0, 1'b1, 0, 1'b1, 0);
    step();
    check_eq("sat hold", 32'(bif.par_err_cnt), 255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
